wb_line_burst_master: RTL and testbench

- Wishbone burst master sitting directly upstream of the memory adapter.
- Converts one cache-line read or write request into a single linear incrementing Wishbone burst: CTI 010 on every beat except the last, CTI 111 on the last, BTE 00, SEL 1111, so the adapter's burst path is always taken.
- Provides a per-beat line-buffer interface to the cache, plus completion, bus-error and watchdog-timeout reporting.

---
 rtl/wb_line_burst_master_pkg.sv | 9 +
 rtl/wb_line_burst_master_if.sv | 22 ++
 rtl/wb_line_burst_master_watchdog.sv | 21 ++
 rtl/wb_line_burst_master.sv | 111 +++++++++++
 tb/tb_wb_line_burst_master.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_line_burst_master_pkg.sv
// wb_line_burst_master_pkg: Wishbone cycle-type constants and the burst master state encoding.
package wb_line_burst_master_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [3:0] SEL_WORD    = 4'b1111;
    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_FINISH} state_t;
endpackage

// File: rtl/wb_line_burst_master_if.sv
// wb_line_burst_master_if: Wishbone master bus between the line burst master and the memory adapter.
interface wb_line_burst_master_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:2] wbm_addr_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic [31:0] wbm_data_o;
    logic [31:0] wbm_data_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_cti_o, wbm_bte_o, wbm_sel_o, wbm_we_o, wbm_data_o,
        input  wbm_data_i, wbm_ack_i, wbm_err_i
    );
    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_cti_o, wbm_bte_o, wbm_sel_o, wbm_we_o, wbm_data_o,
        output wbm_data_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_line_burst_master_watchdog.sv
// wb_line_burst_master_watchdog: stall watchdog; expired pulses on the enabled cycle that takes
// the counter to all-ones, i.e. after 2**TIMEOUT_BITS-1 consecutive enabled cycles.
module wb_line_burst_master_watchdog #(
    parameter int TIMEOUT_BITS = 8
) (
    input  logic wbs_clk_i,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [TIMEOUT_BITS-1:0] LAST = ~TIMEOUT_BITS'(1);
    logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
    always_ff @(posedge wbs_clk_i)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    always_comb begin
        cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
        expired = en && !clr && cnt_q == LAST;
    end
endmodule

// File: rtl/wb_line_burst_master.sv
// wb_line_burst_master: turns one cache-line read/write request into a single linear
// incrementing Wishbone burst, with per-beat line-buffer access and done/err reporting.
module wb_line_burst_master
    import wb_line_burst_master_pkg::*;
#(
    parameter int         LINE_WORDS_BITS = 3,
    parameter int         TIMEOUT_BITS    = 8,
    parameter logic [2:0] BURST_CTI       = CTI_INCR,
    parameter logic [2:0] END_CTI         = CTI_END
) (
    input  logic                       wbs_clk_i,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [31:LINE_WORDS_BITS+2] req_addr,
    output logic [LINE_WORDS_BITS-1:0] wr_idx,
    input  logic [31:0]                wr_data,
    output logic                       rd_valid,
    output logic [LINE_WORDS_BITS-1:0] rd_idx,
    output logic [31:0]                rd_data,
    output logic                       done,
    output logic                       err,
    wb_line_burst_master_if.master     wb
);
    localparam logic [LINE_WORDS_BITS-1:0] LAST_BEAT = '1;

    state_t                        state_q, state_d;
    logic [LINE_WORDS_BITS-1:0]    beat_q, beat_d;
    logic [31:LINE_WORDS_BITS+2]   addr_q, addr_d;
    logic                          we_q, we_d;
    logic                          err_q, err_d;
    logic                          in_burst, beat_ack, bus_err, last_beat;
    logic                          wd_clr, wd_expired;

    assign in_burst  = state_q == ST_BURST;
    assign bus_err   = in_burst && wb.wbm_err_i;
    // err outranks a simultaneous ack: the beat is neither counted nor delivered
    assign beat_ack  = in_burst && wb.wbm_ack_i && !wb.wbm_err_i;
    assign last_beat = beat_q == LAST_BEAT;
    assign wd_clr    = !in_burst || wb.wbm_ack_i || wb.wbm_err_i;

    wb_line_burst_master_watchdog #(.TIMEOUT_BITS(TIMEOUT_BITS)) u_watchdog (
        .wbs_clk_i,
        .rst,
        .clr     (wd_clr),
        .en      (!wd_clr),
        .expired (wd_expired)
    );

    always_ff @(posedge wbs_clk_i)
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE:
                if (req_valid) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                    addr_d  = req_addr;
                    we_d    = req_we;
                end
            ST_BURST:
                if (bus_err || wd_expired) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                end else if (beat_ack) begin
                    if (last_beat) begin
                        state_d = ST_FINISH;
                        err_d   = 1'b0;
                    end else beat_d = beat_q + 1'b1;
                end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = state_q == ST_IDLE;
        wb.wbm_cyc_o  = in_burst;
        wb.wbm_stb_o  = in_burst;
        wb.wbm_we_o   = in_burst && we_q;
        wb.wbm_addr_o = {addr_q, beat_q};
        wb.wbm_cti_o  = !in_burst ? CTI_CLASSIC : last_beat ? END_CTI : BURST_CTI;
        wb.wbm_bte_o  = BTE_LINEAR;
        wb.wbm_sel_o  = SEL_WORD;
        wb.wbm_data_o = wr_data;
        wr_idx        = beat_q;
        rd_idx        = beat_q;
        rd_valid      = beat_ack && !we_q;
        rd_data       = wb.wbm_data_i;
        done          = state_q == ST_FINISH;
        err           = done && err_q;
    end
endmodule

// File: tb/tb_wb_line_burst_master.sv
// tb_wb_line_burst_master: randomized and directed line bursts against a cycle-level reference
// of the master's documented behaviour, plus literal burst-shape expectations.
module tb_wb_line_burst_master;
    localparam int LWB = 3;
    localparam int N   = 8;
    localparam int TB  = 4;
    localparam int TMO = 15;

    logic                wbs_clk_i = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_we = 1'b0;
    logic [31:LWB+2]     req_addr = '0;
    logic                req_ready, rd_valid, done, err;
    logic [LWB-1:0]      wr_idx, rd_idx;
    logic [31:0]         wr_data, rd_data;
    logic [31:0]         lb [N];

    wb_line_burst_master_if wb();

    wb_line_burst_master #(.LINE_WORDS_BITS(LWB), .TIMEOUT_BITS(TB)) dut (
        .wbs_clk_i (wbs_clk_i),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .wb        (wb)
    );

    assign wr_data = lb[wr_idx];
    always #5 wbs_clk_i = ~wbs_clk_i;

    int n_cmp = 0, n_bad = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // reference state: 0 idle, 1 bursting, 2 completion cycle
    int          m_ph = 0, m_beat = 0, m_stall = 0;
    int unsigned m_line = 0;
    logic        m_we = 1'b0, m_err = 1'b0;

    // per-burst shape observed on the bus
    int          cyc_run = 0, low_run = 0, gap = 0, n_rd_b = 0, n_wr_b = 0, n_end_b = 0, dones = 0;
    logic [29:0] first_a = '0, last_a = '0;
    int          l_cyc = 0, l_gap = 0, l_rd = 0, l_wr = 0, l_end = 0;
    logic [29:0] l_first = '0, l_last = '0;
    logic        l_err = 1'b0;

    initial begin : compare
        logic a, e, rv;
        forever begin
            @(negedge wbs_clk_i);
            a  = wb.wbm_ack_i;
            e  = wb.wbm_err_i;
            rv = m_ph == 1 && !m_we && a && !e;
            chk("req_ready", 32'(req_ready), 32'(m_ph == 0));
            chk("cyc", 32'(wb.wbm_cyc_o), 32'(m_ph == 1));
            chk("stb", 32'(wb.wbm_stb_o), 32'(m_ph == 1));
            chk("done", 32'(done), 32'(m_ph == 2));
            chk("bte", 32'(wb.wbm_bte_o), 32'd0);
            chk("sel", 32'(wb.wbm_sel_o), 32'hf);
            chk("rd_valid", 32'(rd_valid), 32'(rv));
            if (m_ph == 2) chk("err", 32'(err), 32'(m_err));
            if (m_ph == 1) begin
                chk("addr", 32'(wb.wbm_addr_o), m_line * N + 32'(m_beat));
                chk("cti", 32'(wb.wbm_cti_o), m_beat == N - 1 ? 32'd7 : 32'd2);
                chk("we", 32'(wb.wbm_we_o), 32'(m_we));
                chk("wr_idx", 32'(wr_idx), 32'(m_beat));
                chk("data_o", wb.wbm_data_o, lb[m_beat]);
            end
            if (rv) begin
                chk("rd_idx", 32'(rd_idx), 32'(m_beat));
                chk("rd_data", rd_data, wb.wbm_data_i);
            end
            if (wb.wbm_cyc_o) begin
                if (cyc_run == 0) begin
                    first_a = wb.wbm_addr_o;
                    gap = low_run;
                    n_rd_b = 0;
                    n_wr_b = 0;
                    n_end_b = 0;
                end
                cyc_run++;
                low_run = 0;
                last_a = wb.wbm_addr_o;
                if (rd_valid) n_rd_b++;
                if (wb.wbm_we_o && a && !e) n_wr_b++;
                if (wb.wbm_cti_o == 3'b111) n_end_b++;
            end else begin
                if (cyc_run != 0) begin
                    l_cyc = cyc_run;
                    l_gap = gap;
                    l_rd = n_rd_b;
                    l_wr = n_wr_b;
                    l_end = n_end_b;
                    l_first = first_a;
                    l_last = last_a;
                end
                cyc_run = 0;
                low_run++;
            end
            if (done) begin
                dones++;
                l_err = err;
            end
            if (rst) m_ph = 0;
            else if (m_ph == 0) begin
                if (req_valid) begin
                    m_ph = 1;
                    m_line = 32'(req_addr);
                    m_we = req_we;
                    m_beat = 0;
                    m_stall = 0;
                end
            end else if (m_ph == 1) begin
                if (e) begin
                    m_ph = 2;
                    m_err = 1'b1;
                end else if (a) begin
                    if (m_beat == N - 1) begin
                        m_ph = 2;
                        m_err = 1'b0;
                    end else begin
                        m_beat++;
                        m_stall = 0;
                    end
                end else begin
                    m_stall++;
                    if (m_stall == TMO) begin
                        m_ph = 2;
                        m_err = 1'b1;
                    end
                end
            end else m_ph = 0;
        end
    end

    // slave: 0 ack every cycle, 1 ack every 3rd cycle, 2 random, 3 never; err (with ack unless random) on err_beat
    int ack_mode = 0, err_beat = -1, sbeats = 0, div = 0;

    task automatic step();
        logic a, e;
        @(posedge wbs_clk_i);
        #2;
        a = 1'b0;
        e = 1'b0;
        if (wb.wbm_cyc_o) begin
            a = ack_mode == 0 ? 1'b1 : ack_mode == 1 ? div == 2 : ack_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
            e = sbeats == err_beat;
            if (e && ack_mode != 2) a = 1'b1;
            div = a ? 0 : div + 1;
            if (a) sbeats++;
        end else begin
            sbeats = 0;
            div = 0;
        end
        wb.wbm_ack_i = a;
        wb.wbm_err_i = e;
        wb.wbm_data_i = $urandom;
    endtask

    task automatic run(input logic we, input logic [31:LWB+2] line, input int mode, input int eb, input logic keep);
        int d0, n;
        d0 = dones;
        n = 0;
        ack_mode = mode;
        err_beat = eb;
        req_valid = 1'b1;
        req_we = we;
        req_addr = line;
        while (dones == d0 && n < 300) begin
            step();
            if (wb.wbm_cyc_o && !keep) req_valid = 1'b0;
            n++;
        end
        chk("done_seen", 32'(dones != d0), 32'd1);
    endtask

    task automatic fill_lb();
        for (int i = 0; i < N; i++) lb[i] = $urandom;
    endtask

    initial begin : stim
        int d0, n;
        logic [31:LWB+2] ln;
        wb.wbm_ack_i = 1'b0;
        wb.wbm_err_i = 1'b0;
        wb.wbm_data_i = '0;
        fill_lb();
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);

        run(1'b0, 27'h8, 0, -1, 1'b0);
        chk("t1_first_addr", 32'(l_first), 32'h40);
        chk("t1_last_addr", 32'(l_last), 32'h47);
        chk("t1_rd_beats", 32'(l_rd), 32'd8);
        chk("t1_cycles", 32'(l_cyc), 32'd8);
        chk("t1_end_cti", 32'(l_end), 32'd1);
        chk("t1_err", 32'(l_err), 32'd0);

        fill_lb();
        run(1'b1, 27'h123, 1, -1, 1'b0);
        chk("t2_first_addr", 32'(l_first), 32'h918);
        chk("t2_wr_beats", 32'(l_wr), 32'd8);
        chk("t2_cycles", 32'(l_cyc), 32'd24);
        chk("t2_end_cti", 32'(l_end), 32'd3);
        chk("t2_err", 32'(l_err), 32'd0);

        run(1'b0, 27'h40, 0, 3, 1'b0);
        chk("t3_rd_beats", 32'(l_rd), 32'd3);
        chk("t3_cycles", 32'(l_cyc), 32'd4);
        chk("t3_err", 32'(l_err), 32'd1);

        run(1'b0, 27'h9, 3, -1, 1'b0);
        chk("t4_cycles", 32'(l_cyc), 32'd15);
        chk("t4_rd_beats", 32'(l_rd), 32'd0);
        chk("t4_err", 32'(l_err), 32'd1);

        ack_mode = 0;
        err_beat = -1;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 27'h55;
        n = 0;
        while (!(wb.wbm_cyc_o && wb.wbm_addr_o[4:2] == 3'd5) && n < 50) begin
            step();
            if (wb.wbm_cyc_o) req_valid = 1'b0;
            n++;
        end
        chk("t5_at_beat5", 32'(wb.wbm_addr_o[4:2]), 32'd5);
        d0 = dones;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_cyc_drop", 32'(wb.wbm_cyc_o), 32'd0);
        chk("t5_stb_drop", 32'(wb.wbm_stb_o), 32'd0);
        repeat (4) step();
        chk("t5_no_done", 32'(dones), 32'(d0));
        run(1'b0, 27'h56, 0, -1, 1'b0);
        chk("t5_restart_addr", 32'(l_first), 32'h2b0);
        chk("t5_restart_rd", 32'(l_rd), 32'd8);

        run(1'b0, 27'h10, 0, -1, 1'b1);
        run(1'b1, 27'h11, 0, -1, 1'b0);
        chk("t6_gap", 32'(l_gap), 32'd2);
        chk("t6_first_addr", 32'(l_first), 32'h88);

        for (int k = 0; k < 80; k++) begin
            fill_lb();
            repeat ($urandom_range(0, 3)) step();
            ln = 27'($urandom);
            run(1'($urandom_range(0, 1)), ln, $urandom_range(0, 2),
                $urandom_range(0, 3) == 0 ? int'($urandom_range(0, N - 1)) : -1, 1'b0);
        end
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
